// File: rtl/mul_arb.sv
// mul_arb: two-requester round-robin arbiter in front of a shared radix-2
// shift-add multiplier (UMULO 16x16 low half, UMULC 8x8 unsigned, SMUL 8x8 signed).
// Latency: grant in cycle T, N CALC cycles (16/8/8/1 by op), DONE with result at T+N+1.
// Backpressure: requests are held until granted; grants only while IDLE, so a
//   waiting requester sees no grant until the unit returns to IDLE. stall = req0 & ~done0.
// Ports: clk, rst (sync, active-high); req0/op0/a0/b0, req1/op1/a1/b1 requests;
//   gnt0/gnt1 and done0/done1 one-cycle pulses; result (held between DONEs);
//   busy (CALC or DONE); stall.
// Build option: define MUL_EARLY_TERM_EN to end CALC once the remaining multiplier
//   bits are all zero (at least 1 cycle, never more than N). Results are unchanged.
module mul_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [1:0]  op0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic        req1,
    input  logic [1:0]  op1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] result,
    output logic        busy,
    output logic        stall
);

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    localparam logic [1:0] OP_UMULO = 2'b00;
    localparam logic [1:0] OP_UMULC = 2'b01;
    localparam logic [1:0] OP_SMUL  = 2'b10;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic        last_id;   // requester granted most recently
    logic        id_q;      // requester owning the current operation
    logic        neg_q;     // SMUL: negate the magnitude product at the end
    logic [4:0]  cnt;       // remaining CALC cycles minus one
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [15:0] mplier;

    // Grant must be seen in the same cycle the request is presented, so the
    // arbitration decision is combinational off the registered state.
    logic idle_ok;
    always_comb begin
        idle_ok = (state == IDLE) && !rst;
        gnt0    = idle_ok && req0 && (!req1 || last_id);
        gnt1    = idle_ok && req1 && (!req0 || !last_id);
        done0   = (state == DONE) && !id_q && !rst;
        done1   = (state == DONE) &&  id_q && !rst;
        busy    = (state != IDLE) && !rst;
        stall   = req0 && !done0;
    end

    // Operand preparation for the winning requester.
    logic [1:0]  op_s;
    logic [15:0] a_s;
    logic [15:0] b_s;
    logic [7:0]  mag_a;
    logic [7:0]  mag_b;
    logic [15:0] ld_mcand;
    logic [15:0] ld_mplier;
    logic [4:0]  ld_cnt;
    logic        ld_neg;

    always_comb begin
        op_s  = gnt1 ? op1 : op0;
        a_s   = gnt1 ? a1  : a0;
        b_s   = gnt1 ? b1  : b0;
        // Two's-complement magnitude; -128 maps to 8'h80, which is still correct unsigned.
        mag_a = a_s[7] ? (8'd0 - a_s[7:0]) : a_s[7:0];
        mag_b = b_s[7] ? (8'd0 - b_s[7:0]) : b_s[7:0];
        ld_mcand  = 16'h0000;
        ld_mplier = 16'h0000;
        ld_cnt    = 5'd0;
        ld_neg    = 1'b0;
        case (op_s)
            OP_UMULO: begin
                ld_mcand  = a_s;
                ld_mplier = b_s;
                ld_cnt    = 5'd15;
            end
            OP_UMULC: begin
                ld_mcand  = {8'h00, a_s[7:0]};
                ld_mplier = {8'h00, b_s[7:0]};
                ld_cnt    = 5'd7;
            end
            OP_SMUL: begin
                ld_mcand  = {8'h00, mag_a};
                ld_mplier = {8'h00, mag_b};
                ld_cnt    = 5'd7;
                ld_neg    = a_s[7] ^ b_s[7];
            end
            default: begin
                // Reserved op: zero operands give a zero result after one cycle.
                ld_mcand  = 16'h0000;
                ld_mplier = 16'h0000;
                ld_cnt    = 5'd0;
            end
        endcase
    end

    // One shift-add step per CALC cycle.
    logic [15:0] acc_nxt;
    logic [15:0] mplier_nxt;
    logic [15:0] prod;
    logic        finish;

    always_comb begin
        acc_nxt    = acc + (mplier[0] ? mcand : 16'h0000);
        mplier_nxt = {1'b0, mplier[15:1]};
        prod       = neg_q ? (16'h0000 - acc_nxt) : acc_nxt;
        finish     = (cnt == 5'd0) || (EARLY_TERM && (mplier_nxt == 16'h0000));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_id <= 1'b1;   // requester 0 wins the first contention
            id_q    <= 1'b0;
            neg_q   <= 1'b0;
            cnt     <= 5'd0;
            acc     <= 16'h0000;
            mcand   <= 16'h0000;
            mplier  <= 16'h0000;
            result  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        state   <= CALC;
                        id_q    <= gnt1;
                        last_id <= gnt1;
                        neg_q   <= ld_neg;
                        cnt     <= ld_cnt;
                        acc     <= 16'h0000;
                        mcand   <= ld_mcand;
                        mplier  <= ld_mplier;
                    end
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= {mcand[14:0], 1'b0};
                    mplier <= mplier_nxt;
                    cnt    <= cnt - 5'd1;
                    if (finish) begin
                        state  <= DONE;
                        result <= prod;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arb.sv
// tb_mul_arb: directed, table-driven bench for mul_arb.
// Inputs are driven on the falling edge and outputs sampled 1 ns later.
module tb_mul_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1, busy, stall;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_arb dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .busy(busy), .stall(stall)
    );

    typedef struct {
        bit          id;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected cycles from grant to done, derived from op and multiplier.
    function automatic int exp_lat(input logic [1:0] op, input logic [15:0] b);
        int n;
        logic [15:0] m;
        int k;
        n = (op == 2'b00) ? 16 : (op == 2'b11) ? 1 : 8;
        m = 16'h0000;
        k = 0;
        if (op == 2'b00) m = b;
        else if (op == 2'b01) m = {8'h00, b[7:0]};
        else if (op == 2'b10) m = {8'h00, (b[7] ? (8'd0 - b[7:0]) : b[7:0])};
        for (int i = 0; i < 16; i++) if (m[i]) k = i + 1;
        if (k == 0) k = 1;
        if (k > n) k = n;
`ifdef MUL_EARLY_TERM_EN
        return k + 1;
`else
        return n + 1;
`endif
    endfunction

    // Entered at a falling edge; leaves at the falling edge after done, requests low.
    task automatic run_txn(input bit id, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, output int lat, output logic [15:0] res,
                           output bit got);
        int t;
        got = 1'b0;
        lat = -1;
        res = 16'hxxxx;
        if (id) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        #1;
        t = 0;
        while (!(id ? gnt1 : gnt0) && t < 5) begin
            @(negedge clk); #1; t++;
        end
        if (!(id ? gnt1 : gnt0)) begin
            req0 = 1'b0; req1 = 1'b0;
            return;
        end
        if (!id) chk("stall_at_grant", stall, 1'b1);
        got = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (id) req1 = 1'b0;
            #1;
            lat++;
            if (id ? done1 : done0) break;
        end
        res = result;
        if (!id) chk("stall_at_done", stall, 1'b0);
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // No two grants or two dones in the same cycle, ever.
    always @(negedge clk) begin
        #2;
        checks++;
        if ((gnt0 && gnt1) || (done0 && done1)) begin
            errors++;
            $display("FAIL exclusive_pulses: gnt=%b%b done=%b%b expected at most one each",
                     gnt0, gnt1, done0, done1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[12];
        int          lat;
        logic [15:0] res;
        logic [15:0] prev;
        bit          got;
        int          gseq[$];
        int          t;

        vecs[0]  = '{1'b0, 2'b00, 16'h1234, 16'h0010, 16'h2340};
        vecs[1]  = '{1'b1, 2'b01, 16'hABFF, 16'h12FF, 16'hFE01};
        vecs[2]  = '{1'b0, 2'b10, 16'h00FF, 16'h0005, 16'hFFFB};
        vecs[3]  = '{1'b0, 2'b10, 16'h0080, 16'h0080, 16'h4000};
        vecs[4]  = '{1'b0, 2'b00, 16'h0007, 16'h0003, 16'h0015};
        vecs[5]  = '{1'b1, 2'b00, 16'hFFFF, 16'hFFFF, 16'h0001};
        vecs[6]  = '{1'b0, 2'b11, 16'h1234, 16'h5678, 16'h0000};
        vecs[7]  = '{1'b1, 2'b10, 16'h0003, 16'h00FE, 16'hFFFA};
        vecs[8]  = '{1'b0, 2'b01, 16'hFF10, 16'hEE10, 16'h0100};
        vecs[9]  = '{1'b1, 2'b10, 16'h0080, 16'h0001, 16'hFF80};
        vecs[10] = '{1'b0, 2'b00, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[11] = '{1'b0, 2'b10, 16'h007F, 16'h0081, 16'hC0FF};

        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b0;
        op0 = 2'b00; op1 = 2'b00;
        a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0;

        // Reset state, with req0 high to see stall during reset.
        @(negedge clk); @(negedge clk); #1;
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_done", {done0, done1}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", result, 16'h0000);
        chk("rst_stall", stall, 1'b1);
        req0 = 1'b0;
        #1;
        chk("rst_stall_low", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Table of single transactions.
        prev = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, lat, res, got);
            chk($sformatf("vec%0d_granted", i), got, 1'b1);
            chk($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].op, vecs[i].b));
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            prev = vecs[i].exp;
        end

        // Result holds across IDLE and into the next CALC.
        req0 = 1'b1; op0 = 2'b00; a0 = 16'h0002; b0 = 16'h0003;
        #1;
        chk("hold_gnt", gnt0, 1'b1);
        @(negedge clk); #1;
        chk("hold_busy", busy, 1'b1);
        chk("hold_result", result, prev);
        t = 0;
        while (!done0 && t < 40) begin @(negedge clk); #1; t++; end
        chk("hold_done_result", result, 16'h0006);
        @(negedge clk);
        req0 = 1'b0;

        // Withdrawn request and no grant outside IDLE.
        req0 = 1'b1; op0 = 2'b11;
        #1;
        chk("wd_gnt0", gnt0, 1'b1);
        @(negedge clk);
        req1 = 1'b1;
        #1;
        chk("wd_no_gnt1_calc", gnt1, 1'b0);
        @(negedge clk); #1;
        chk("wd_done0", done0, 1'b1);
        chk("wd_no_gnt1_done", gnt1, 1'b0);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        #1;
        chk("wd_no_grant_idle", {gnt0, gnt1}, 2'b00);
        chk("wd_idle", busy, 1'b0);

        // Round-robin under continuous contention from reset release.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; op0 = 2'b11; op1 = 2'b11;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (gnt0) gseq.push_back(0);
            if (gnt1) gseq.push_back(1);
            @(negedge clk);
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_grant_count", (gseq.size() >= 5), 1'b1);
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr_grant%0d", k), (k < gseq.size()) ? gseq[k] : -1, k % 2);
        repeat (3) @(negedge clk);

        // Reset in the 5th CALC cycle aborts, then a fresh req0 is granted at once.
        req0 = 1'b1; op0 = 2'b00; a0 = 16'h1234; b0 = 16'h0100;
        #1;
        chk("abort_gnt", gnt0, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_no_done", done0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_idle", busy, 1'b0);
        chk("abort_done", done0, 1'b0);
        chk("abort_result", result, 16'h0000);
        chk("abort_regrant", gnt0, 1'b1);
        t = 0;
        while (!done0 && t < 40) begin @(negedge clk); #1; t++; end
        chk("abort_fresh_latency", t, exp_lat(2'b00, 16'h0100));
        chk("abort_fresh_result", result, 16'h3400);
        @(negedge clk);
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_arb.md
MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 Parameters: none; operation codes fixed: 2'b00 UMULO, 2'b01 UMULC, 2'b10 SMUL, 2'b11 reserved.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req0  input  1  requester 0 (EX pipeline) multiply request, held high until gnt0.
REQ-005 op0  input  2  requester 0 operation code.
REQ-006 a0, b0  input  16 each  requester 0 operands.
REQ-007 req1  input  1  requester 1 (secondary) multiply request, held high until gnt1.
REQ-008 op1  input  2  requester 1 operation code.
REQ-009 a1, b1  input  16 each  requester 1 operands.
REQ-010 gnt0, gnt1  output  1 each  one-cycle grant pulses; operands captured that cycle.
REQ-011 done0, done1  output  1 each  one-cycle completion pulses to the granted requester.
REQ-012 result  output  16  product of most recent completed operation.
REQ-013 busy  output  1  high in CALC and DONE.
REQ-014 stall  output  1  req0 & ~done0; freezes the pipeline while requester 0 waits.

Function
REQ-015 FSM states IDLE, CALC, DONE; IDLE->CALC on any grant; CALC->DONE when iteration count expires; DONE->IDLE unconditionally.
REQ-016 Grants issued only in IDLE; at most one of gnt0/gnt1 high per cycle.
REQ-017 Arbitration round-robin: with both requests pending, grant goes to the requester not granted last; single pending request granted immediately.
REQ-018 Grant cycle latches op, operands and requester id; inputs ignored thereafter until next IDLE.
REQ-019 Iteration: radix-2 shift-add, one multiplier bit per CALC cycle; N = 16 for UMULO, 8 for UMULC and SMUL, 1 for reserved.
REQ-020 UMULO: result = low 16 bits of a*b, both 16-bit unsigned.
REQ-021 UMULC: result = a[7:0]*b[7:0] unsigned, full 16-bit product; upper operand bytes ignored.
REQ-022 SMUL: result = a[7:0]*b[7:0] as signed 8-bit two's complement, 16-bit signed product; -128*-128 = 16'h4000.
REQ-023 Reserved op: result = 16'h0000.
REQ-024 Latency: grant at cycle T, CALC cycles T+1..T+N, DONE at T+N+1 with doneX and result valid.
REQ-025 result updates only in DONE and holds until the next DONE.
REQ-026 Withdrawn request (reqX low before gntX) is dropped, no grant issued.
REQ-027 Requester may re-request the cycle after doneX; earliest next grant is the cycle after DONE.

Reset
REQ-028 rst high: state IDLE, gnt0/gnt1/done0/done1/busy low, result 16'h0000, last-grant set to requester 1 so requester 0 wins first contention.
REQ-029 rst during CALC or DONE aborts the operation; no done pulse issued for it.
REQ-030 stall follows REQ-014 combinationally during and after reset.

Configuration
REQ-031 Macro MUL_EARLY_TERM_EN defined: CALC ends after the cycle in which the remaining shifted multiplier (magnitude for SMUL) becomes zero, minimum 1 CALC cycle, capped at N.
REQ-032 MUL_EARLY_TERM_EN undefined: CALC always lasts exactly N cycles; results identical in both builds.

Verification
REQ-033 req0, UMULO, a0=16'h1234, b0=16'h0010 at cycle 0 -> gnt0 cycle 0, done0 cycle 17, result 16'h2340, stall high cycles 0-16.
REQ-034 req1, UMULC, a1=16'hABFF, b1=16'h12FF -> done1 9 cycles after gnt1, result 16'hFE01.
REQ-035 req0, SMUL, a0=16'h00FF, b0=16'h0005 -> result 16'hFFFB; a0=16'h0080, b0=16'h0080 -> 16'h4000.
REQ-036 req0 and req1 held high continuously from reset release -> grants alternate gnt0, gnt1, gnt0, ...; never both in one cycle.
REQ-037 rst asserted at 5th CALC cycle -> next cycle IDLE, no done pulse, result 16'h0000; fresh req0 granted immediately after.
REQ-038 MUL_EARLY_TERM_EN defined, UMULO a0=16'h0007, b0=16'h0003 -> 2 CALC cycles, done0 at cycle 3, result 16'h0015; undefined -> done0 at cycle 17, same result.
